// File: rtl/sig_dev_pkg.sv
// Shared constants and FSM state encoding for the signature store sink.
package sig_dev_pkg;

    localparam logic [31:0] SIG_ADDR_DEF  = 32'h0000_0f00;
    localparam logic [31:0] HALT_ADDR_DEF = 32'hcafe_beef;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sig_state_e;

endpackage

// File: rtl/sig_fifo.sv
// Synchronous FIFO with occupancy counter; head word is presented as soon as it is written.
module sig_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO only lands when a slot is freed the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = empty ? '0 : mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/sig_store_sink.sv
// Signature store sink: captures stores to SIG_ADDR into a FIFO stream, halts after a HALT_ADDR store drains it.
// Define SIGDEV_STALL_EN to back-pressure the pipeline instead of dropping stores into a full FIFO.
module sig_store_sink
    import sig_dev_pkg::*;
#(
    parameter logic [31:0] SIG_ADDR  = SIG_ADDR_DEF,
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF,
    parameter int          DW        = 32,
    parameter int          DEPTH     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            addr,
    input  logic [DW-1:0]          data_wr,
    input  logic                   wr,
    output logic [DW-1:0]          sig_data,
    output logic                   sig_valid,
    input  logic                   sig_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   halt
`ifdef SIGDEV_STALL_EN
    ,
    output logic                   stall
`endif
);

    sig_state_e state_reg;
    sig_state_e state_next;

    logic is_sig;
    logic is_halt;
    logic push_req;
    logic push;
    logic pop;
    logic full;
    logic empty;
    logic blocked;

    // wr is the data-memory strobe and is active low.
    assign is_sig   = ~wr & (addr == SIG_ADDR);
    assign is_halt  = ~wr & (addr == HALT_ADDR);
    assign push_req = (state_reg == RUN) & is_sig;
    assign pop      = sig_valid & sig_ready;
    assign blocked  = push_req & full & ~pop;
    assign push     = push_req & ~blocked;
    assign sig_valid = ~empty;

    sig_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_wr),
        .head  (sig_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef SIGDEV_STALL_EN
    assign stall    = blocked;
    assign overflow = 1'b0;
`else
    logic overflow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (blocked) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN looks at the registered count, so the final pop is seen one cycle later.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (is_halt) state_next = DRAIN;
            DRAIN:   if (empty)   state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    assign halt = (state_reg == HALTED);

endmodule

// File: tb/tb_sig_store_sink.sv
// Randomised + directed bench for sig_store_sink against a queue-based reference model.
module tb_sig_store_sink;

    localparam logic [31:0] SIG  = 32'h0000_0f00;
    localparam logic [31:0] HLT  = 32'hcafe_beef;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] data_wr = '0;
    logic        wr = 1'b1;
    logic [31:0] sig_data;
    logic        sig_valid;
    logic        sig_ready = 1'b0;
    logic [3:0]  count;
    logic        overflow;
    logic        halt;
    logic        stall;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered words, sticky overflow, and phase (0 run, 1 drain, 2 halted).
    logic [31:0] q [$];
    bit          m_ovf;
    int          m_st;

    always #5 clk = ~clk;

    sig_store_sink dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data_wr   (data_wr),
        .wr        (wr),
        .sig_data  (sig_data),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .count     (count),
        .overflow  (overflow),
        .halt      (halt)
`ifdef SIGDEV_STALL_EN
        ,
        .stall     (stall)
`endif
    );

`ifndef SIGDEV_STALL_EN
    assign stall = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        addr = a;
        data_wr = d;
        wr = w;
        sig_ready = r;
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        cyc(32'h0, 32'h0, 1'b1, r);
    endtask

    // Compare process: mid-cycle, check outputs against the model, then advance the model for the coming edge.
    initial begin
        bit pop_now, sig_st, stall_exp;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                q.delete();
                m_ovf = 0;
                m_st = 0;
            end
            pop_now   = (q.size() > 0) && sig_ready;
            sig_st    = !wr && (addr == SIG);
            stall_exp = (m_st == 0) && sig_st && (q.size() == DEPTH) && !pop_now;
            chk("m_valid", {31'b0, sig_valid}, {31'b0, q.size() > 0});
            chk("m_data", sig_data, (q.size() > 0) ? q[0] : 32'h0);
            chk("m_count", {28'b0, count}, q.size());
            chk("m_halt", {31'b0, halt}, {31'b0, m_st == 2});
            chk("m_ovf", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef SIGDEV_STALL_EN
            chk("m_stall", {31'b0, stall}, {31'b0, stall_exp});
`endif
            if (!rst) begin
                if (m_st == 1 && q.size() == 0) m_st = 2;
                if (pop_now) begin
                    $display("pop data=%h count_before=%0d", q[0], q.size());
                    void'(q.pop_front());
                end
                if (m_st == 0 && sig_st) begin
                    if (q.size() < DEPTH) q.push_back(data_wr);
`ifndef SIGDEV_STALL_EN
                    else m_ovf = 1;
`endif
                end
                if (m_st == 0 && !wr && addr == HLT) m_st = 1;
                // stall_exp only consumed in the stall build
                if (stall_exp && 0) $display("stall");
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        idle(0);
        idle(0);
        rst = 1'b0;
        #1;
        chk("rst_count", {28'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, sig_valid}, 32'd0);
        chk("rst_halt", {31'b0, halt}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);

        // Single store, consumed one cycle later.
        cyc(SIG, 32'h1234_5678, 1'b0, 1'b1);
        #1;
        chk("t1_valid", {31'b0, sig_valid}, 32'd1);
        chk("t1_data", sig_data, 32'h1234_5678);
        idle(1);
        #1;
        chk("t1_count0", {28'b0, count}, 32'd0);

        // Fill to full, then a ninth store.
        for (int i = 0; i < 8; i++) cyc(SIG, i, 1'b0, 1'b0);
        #1;
        chk("t2_full", {28'b0, count}, 32'd8);
        cyc(SIG, 32'h99, 1'b0, 1'b0);
        #1;
        chk("t2_count9", {28'b0, count}, 32'd8);
`ifdef SIGDEV_STALL_EN
        chk("t2_stall", {31'b0, stall}, 32'd1);
        chk("t2_head0", sig_data, 32'd0);
        cyc(SIG, 32'h99, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            #1;
            chk("t2_drain", sig_data, i);
            idle(1);
        end
        #1;
        chk("t2_held", sig_data, 32'h99);
        idle(1);
`else
        chk("t2_ovf", {31'b0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_drain", sig_data, i);
            idle(1);
        end
`endif
        #1;
        chk("t2_empty", {28'b0, count}, 32'd0);

        // Full FIFO with simultaneous push and pop.
        rst = 1'b1;
        idle(0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(SIG, 32'h10 + i, 1'b0, 1'b0);
        cyc(SIG, 32'hAA, 1'b0, 1'b1);
        #1;
        chk("t3_count", {28'b0, count}, 32'd8);
        chk("t3_ovf", {31'b0, overflow}, 32'd0);
        for (int i = 0; i < 7; i++) idle(1);
        #1;
        chk("t3_last", sig_data, 32'hAA);
        idle(1);

        // Halt with three buffered words and toggling ready; a signature store during DRAIN is dropped.
        for (int i = 0; i < 3; i++) cyc(SIG, 32'h30 + i, 1'b0, 1'b0);
        cyc(HLT, 32'h0, 1'b0, 1'b0);
        k = 0;
        while (!halt && k < 20) begin
            #1;
            if (count != 0) chk("t4_nohalt", {31'b0, halt}, 32'd0);
            if (k == 1) cyc(SIG, 32'h5555, 1'b0, k[0]);
            else idle(k[0]);
            k++;
        end
        #1;
        chk("t4_halt", {31'b0, halt}, 32'd1);
        chk("t4_count", {28'b0, count}, 32'd0);
        cyc(SIG, 32'h66, 1'b0, 1'b0);
        #1;
        chk("t4_ignored", {28'b0, count}, 32'd0);

        // Halt store with empty FIFO: halt on the second edge.
        rst = 1'b1;
        idle(0);
        rst = 1'b0;
        cyc(HLT, 32'h0, 1'b0, 1'b0);
        #1;
        chk("t5_halt_e1", {31'b0, halt}, 32'd0);
        idle(0);
        #1;
        chk("t5_halt_e2", {31'b0, halt}, 32'd1);

        // Non-matching stores, then reset mid-DRAIN.
        rst = 1'b1;
        idle(0);
        rst = 1'b0;
        cyc(SIG, 32'h77, 1'b1, 1'b0);
        cyc(32'h0000_0f04, 32'h78, 1'b0, 1'b0);
        #1;
        chk("t6_nopush", {28'b0, count}, 32'd0);
        cyc(SIG, 32'h1, 1'b0, 1'b0);
        cyc(SIG, 32'h2, 1'b0, 1'b0);
        cyc(HLT, 32'h0, 1'b0, 1'b0);
        idle(0);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_count", {28'b0, count}, 32'd0);
        chk("t6_rst_valid", {31'b0, sig_valid}, 32'd0);
        chk("t6_rst_data", sig_data, 32'd0);
        chk("t6_rst_halt", {31'b0, halt}, 32'd0);
        idle(0);
        rst = 1'b0;

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 50)      a = SIG;
            else if (r < 51) a = HLT;
            else if (r < 65) a = 32'h0000_0f04;
            else if (r < 75) a = SIG ^ (32'h1 << $urandom_range(0, 31));
            else             a = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #1;
                rst = 1'b1;
                idle(0);
                rst = 1'b0;
            end
            cyc(a, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        idle(0);
        idle(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
